// File: rtl/divi_pkg.sv
// Shared definitions for the divi fixed-latency signed divider: state encoding,
// default operand width and result latency (edges from capture to valid).
package divi_pkg;

    localparam int DIVI_WIDTH = 32;
    localparam int DIVI_LAT   = DIVI_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } divi_state_t;

endpackage

// File: rtl/divi_step.sv
// One combinational restoring-division step on unsigned magnitudes: shift in the
// next dividend bit, trial-subtract the divisor, keep the difference if it is non-negative.
module divi_step
    import divi_pkg::*;
#(
    parameter int WIDTH = DIVI_WIDTH
) (
    input  logic [WIDTH-1:0] rem_cur,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] dsr_mag,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // The partial remainder is always below the divisor magnitude, so the
    // shifted value fits WIDTH+1 bits and the trial's top bit is its sign.
    always_comb begin
        shifted  = {rem_cur, dvd_bit};
        trial    = shifted - {1'b0, dsr_mag};
        q_bit    = ~trial[WIDTH];
        rem_next = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/divi.sv
// Fixed-latency signed divider: one restoring step per clock, truncating toward zero.
// Define DIVI_ZERO_FAST_EN to finish a zero-divisor request one edge after capture.
module divi
    import divi_pkg::*;
#(
    parameter int WIDTH = DIVI_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] dvdnd,
    input  logic [WIDTH-1:0] dvsor,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    input  logic             start,
    output logic             valid,
    output logic             divz
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    divi_state_t    state;
    logic [CW-1:0]  cnt;
    logic [WIDTH-1:0] rem_mag;
    logic [WIDTH-1:0] dq;
    logic [WIDTH-1:0] dsr_mag;
    logic           dvd_neg;
    logic           dsr_neg;
    logic           dsr_zero;

    logic           capture;
    logic [WIDTH-1:0] in_dvd_mag;
    logic [WIDTH-1:0] in_dsr_mag;
    logic [WIDTH-1:0] rem_step;
    logic           q_step;
    logic [WIDTH-1:0] quot_fix;
    logic [WIDTH-1:0] rem_fix;

    divi_step #(.WIDTH(WIDTH)) u_step (
        .rem_cur  (rem_mag),
        .dvd_bit  (dq[WIDTH-1]),
        .dsr_mag  (dsr_mag),
        .rem_next (rem_step),
        .q_bit    (q_step)
    );

    // dq starts as the dividend magnitude and fills with quotient bits from the
    // right; with a zero divisor it is frozen so it still holds the dividend at the end.
    always_comb begin
        capture    = start && ((state == IDLE) || ((state == DONE) && valid));
        in_dvd_mag = dvdnd[WIDTH-1] ? -dvdnd : dvdnd;
        in_dsr_mag = dvsor[WIDTH-1] ? -dvsor : dvsor;
        if (dsr_zero) begin
            quot_fix = '1;
            rem_fix  = dvd_neg ? -dq : dq;
        end else begin
            quot_fix = (dvd_neg ^ dsr_neg) ? -dq : dq;
            rem_fix  = dvd_neg ? -rem_mag : rem_mag;
        end
    end

    // NOTE: the datapath registers share the async reset so an abort mid-RUN
    // leaves no stale operands; all state is updated with non-blocking assigns.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            rem_mag  <= '0;
            dq       <= '0;
            dsr_mag  <= '0;
            dvd_neg  <= 1'b0;
            dsr_neg  <= 1'b0;
            dsr_zero <= 1'b0;
            quot     <= '0;
            rem      <= '0;
            valid    <= 1'b0;
            divz     <= 1'b0;
        end else if (capture) begin
            dq       <= in_dvd_mag;
            rem_mag  <= '0;
            dsr_mag  <= in_dsr_mag;
            dvd_neg  <= dvdnd[WIDTH-1];
            dsr_neg  <= dvsor[WIDTH-1];
            dsr_zero <= (dvsor == '0);
            cnt      <= '0;
            valid    <= 1'b0;
`ifdef DIVI_ZERO_FAST_EN
            state    <= (dvsor == '0) ? DONE : RUN;
`else
            state    <= RUN;
`endif
        end else begin
            case (state)
                RUN: begin
                    if (!dsr_zero) begin
                        rem_mag <= rem_step;
                        dq      <= {dq[WIDTH-2:0], q_step};
                    end
                    if (cnt == CW'(WIDTH - 1)) begin
                        cnt   <= '0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    // First DONE cycle publishes the result; the next one hands back to IDLE.
                    if (!valid) begin
                        quot  <= quot_fix;
                        rem   <= rem_fix;
                        divz  <= dsr_zero;
                        valid <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divi.sv
// Scoreboard bench for divi: stimulus pushes expected results with their due edge,
// a negedge monitor pops and compares each time valid rises.
module tb_divi;
    import divi_pkg::*;

    localparam int W = DIVI_WIDTH;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dvdnd = '0;
    logic [W-1:0] dvsor = '0;
    logic [W-1:0] quot;
    logic [W-1:0] rem;
    logic         valid;
    logic         divz;

    divi #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .dvdnd (dvdnd),
        .dvsor (dvsor),
        .quot  (quot),
        .rem   (rem),
        .start (start),
        .valid (valid),
        .divz  (divz)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
        int          at;
        string       tag;
        logic        model;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic int lat_for(input logic [31:0] b);
`ifdef DIVI_ZERO_FAST_EN
        if (b == 32'd0) return 1;
`endif
        return DIVI_LAT;
    endfunction

    // Drives one request; returns 1ns after the capture edge with start still high.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] q,
                         input logic [31:0] r, input logic z, input string tag, input logic model);
        exp_t e;
        #1;
        dvdnd = a;
        dvsor = b;
        start = 1'b1;
        @(posedge clock);
        #1;
        e.q = q; e.r = r; e.z = z; e.at = cyc + lat_for(b);
        e.tag = tag; e.model = model; e.a = a; e.b = b;
        sb.push_back(e);
    endtask

    task automatic single(input logic [31:0] a, input logic [31:0] b, input logic [31:0] q,
                          input logic [31:0] r, input logic z, input string tag);
        issue(a, b, q, r, z, tag, 1'b0);
        start = 1'b0;
        repeat (36) @(posedge clock);
    endtask

    // Monitor
    logic prev_valid = 1'b0;
    exp_t m;
    logic signed [31:0] recon;
    logic [31:0] abs_r;
    logic [31:0] abs_b;

    always @(negedge clock) begin
        if (valid && !prev_valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid: got valid at edge %0d, expected none", cyc);
            end else begin
                m = sb.pop_front();
                check({m.tag, "_quot"}, quot, m.q);
                check({m.tag, "_rem"}, rem, m.r);
                check({m.tag, "_divz"}, {31'd0, divz}, {31'd0, m.z});
                check({m.tag, "_edge"}, cyc, m.at);
                if (m.model) begin
                    recon = $signed(quot) * $signed(m.b) + $signed(rem);
                    check({m.tag, "_ident"}, recon, m.a);
                    abs_r = rem[31] ? -rem : rem;
                    abs_b = m.b[31] ? -m.b : m.b;
                    check({m.tag, "_remmag"}, {31'd0, abs_r < abs_b}, 32'd1);
                end
            end
        end
        prev_valid = valid;
    end

    initial begin
        logic signed [31:0] ra;
        logic signed [31:0] rb;

        repeat (3) @(posedge clock);
        #1;
        check("rst_quot", quot, 32'd0);
        check("rst_rem", rem, 32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_divz", {31'd0, divz}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(posedge clock);

        single(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, "p100_p7");
        single(-32'sd100, 32'd7, -32'sd14, -32'sd2, 1'b0, "n100_p7");
        single(32'd100, -32'sd7, -32'sd14, 32'd2, 1'b0, "p100_n7");
        single(32'd7, 32'd0, 32'hFFFF_FFFF, 32'd7, 1'b1, "p7_z");
        single(-32'sd1, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "n1_z");
        single(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, "min_n1");
        single(-32'sd7, -32'sd2, 32'd3, -32'sd1, 1'b0, "n7_n2");
        single(32'd5, 32'd9, 32'd0, 32'd5, 1'b0, "p5_p9");
        single(32'h7FFF_FFFF, 32'd1, 32'h7FFF_FFFF, 32'd0, 1'b0, "max_p1");
        single(32'h8000_0000, 32'h8000_0000, 32'd1, 32'd0, 1'b0, "min_min");

        // start pulsed during RUN must be ignored and not queued
        issue(32'd500, 32'd7, 32'd71, 32'd3, 1'b0, "ignore", 1'b0);
        start = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        dvdnd = 32'd9;
        dvsor = 32'd2;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (40) @(posedge clock);

        // reset ten edges into an operation aborts it
        #1;
        dvdnd = 32'd123456;
        dvsor = -32'sd789;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("abort_quot", quot, 32'd0);
        check("abort_rem", rem, 32'd0);
        check("abort_valid", {31'd0, valid}, 32'd0);
        check("abort_divz", {31'd0, divz}, 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        single(32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, "p1000_p3");

        // start held high: back-to-back captures every WIDTH+2 cycles
        for (int i = 0; i < 10; i++) begin
            ra = $signed($urandom());
            if (i % 2 == 0) begin
                rb = $signed($urandom_range(1, 1000));
                if ($urandom_range(0, 1) == 1) rb = -rb;
            end else begin
                rb = $signed($urandom());
                if (rb == 0) rb = 32'sd13;
            end
            if (ra == 32'sh8000_0000 && rb == -32'sd1) rb = 32'sd3;
            if (i > 0) begin
                repeat (33) @(posedge clock);
            end
            issue(ra, rb, ra / rb, ra % rb, 1'b0, $sformatf("rnd%0d", i), 1'b1);
        end
        start = 1'b0;
        repeat (40) @(posedge clock);

        check("sb_drained", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/divi.md
# divi

Fixed-latency signed integer divider, the inverse companion to the fixed-latency multiplier in the arithmetic datapath. It accepts a dividend/divisor pair on a `start` request and iterates one restoring-division step per clock. It returns a truncated quotient and remainder after a constant number of cycles, with a `valid` flag. Its port ordering and start/valid handshake match the multiplier, so the same bench style and the same controllers drive both.

## Interface
- `WIDTH`, default 32: operand, quotient and remainder width in bits; must be ≥ 2.
- `clock`  in  1: rising-edge clock.
- `reset`  in  1: asynchronous, active-low reset.
- `dvdnd`  in  WIDTH: signed dividend.
- `dvsor`  in  WIDTH: signed divisor.
- `quot`  out  WIDTH: signed quotient.
- `rem`  out  WIDTH: signed remainder.
- `start`  in  1: request; level-sampled while the block is idle or done.
- `valid`  out  1: `quot`, `rem` and `divz` hold a completed result.
- `divz`  out  1: the completed operation had a zero divisor.

## Operation
- States are IDLE, RUN and DONE.
- **IDLE**
  - If `start`=1: capture `dvdnd`, `dvsor` and both sign bits.
  - Load magnitudes, clear the partial remainder, set step counter = 0, go to RUN.
- **RUN**
  - One restoring step per cycle: shift the remainder/dividend pair left 1, trial-subtract the divisor magnitude, and set the quotient bit on a non-negative result.
  - After WIDTH steps, go to DONE.
  - `start` and input changes are ignored; operands were captured at entry.
- **DONE**
  - Register the sign-corrected `quot` and `rem`, and assert `valid`.
  - If `start`=1: capture a new operation as in IDLE, deassert `valid`, go to RUN.
  - Otherwise go to IDLE with `valid` and the outputs held.
- **IDLE with valid=1**: outputs stay stable until the next capture, which clears `valid`.
- **Arithmetic**
  - Truncating division toward zero.
  - Quotient is negative when the operand signs differ.
  - Remainder takes the sign of the dividend, so `dvdnd` = `quot`·`dvsor` + `rem`.
- **Divisor = 0**: `quot` = all ones, `rem` = `dvdnd`, `divz`=1.
- **Most-negative ÷ −1**: `quot` wraps to the most-negative value, `rem`=0, `divz`=0.
- **Magnitudes** are held unsigned WIDTH bits, so the most-negative value's magnitude is representable.

## Timing
- Reset values: `quot`=0, `rem`=0, `valid`=0, `divz`=0, state IDLE, counter 0.
- Reset asserted mid-RUN aborts the operation immediately.
- Capture happens on edge 0, when `start`=1 is seen in IDLE or DONE.
- `valid` rises on edge WIDTH+1: edge 33 for the default WIDTH.
- Latency is independent of operand values (configuration aside).
- With `start` held high continuously, captures repeat every WIDTH+2 cycles. `valid` is high for exactly one cycle per result.
- `start` asserted during RUN has no effect and is not queued.

## Configuration
- Macro `DIVI_ZERO_FAST_EN`.
- **Defined:** a zero divisor detected at capture skips RUN; the block goes to DONE next, so `valid` rises on edge 1 with the divide-by-zero result.
- **Undefined:** a zero divisor runs the full WIDTH steps; `valid` rises on edge WIDTH+1, giving strictly fixed latency.

## Structure
- Package `divi_pkg` holds:
  - the state enumeration (IDLE, RUN, DONE);
  - the default WIDTH constant;
  - a latency constant, `DIVI_LAT` = WIDTH+1.
- Sub-module `divi_step`: combinational single restoring step.
  - Inputs: partial remainder, dividend bits, divisor magnitude.
  - Outputs: next remainder, next quotient bit.
- `divi` owns the FSM, the counter and the sign correction.

## Test plan
- Reset low, then high; `start`=1 with 100 ÷ 7 → `valid` on edge 33 with `quot`=14, `rem`=2, `divz`=0.
- −100 ÷ 7 → `quot`=−14, `rem`=−2; 100 ÷ −7 → `quot`=−14, `rem`=2.
- 7 ÷ 0 → `quot`=0xFFFFFFFF, `rem`=7, `divz`=1.
  - Edge 33 with the macro undefined; edge 1 with `DIVI_ZERO_FAST_EN` defined.
- 0x80000000 ÷ −1 → `quot`=0x80000000, `rem`=0, `divz`=0.
- Assert `reset` low at edge 10 of an operation → all outputs 0 at once.
  - Release, start 1000 ÷ 3 → `quot`=333, `rem`=1 at edge 33 after capture.
- Hold `start` high with 10 random pairs → each result valid one cycle, 34 cycles apart.
  - Each result is checked against a reference model, where `dvdnd` = `quot`·`dvsor` + `rem` and \|`rem`\| < \|`dvsor`\|.
